// File: rtl/cpa_rr_arbiter_if.sv
// Request/result bundle between the requesters, the shared CPA arbiter and the result consumer.
// slave: arbiter side. master: requester/consumer side.
interface cpa_rr_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_lmode;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_sum;
  logic            out_lmode;
  logic [IDW-1:0]  out_id;
  logic            out_last;
  logic            busy;

  modport slave (
    input  req_valid, req_last, req_lmode, req_a, req_b, out_ready,
    output req_ready, out_valid, out_sum, out_lmode, out_id, out_last, busy
  );

  modport master (
    output req_valid, req_last, req_lmode, req_a, req_b, out_ready,
    input  req_ready, out_valid, out_sum, out_lmode, out_id, out_last, busy
  );
endinterface

// File: rtl/cpa_rr_arbiter.sv
// Round-robin arbiter sharing one lane-splittable 32/16-bit carry-propagate adder among N requesters.
// Bursts lock the adder to one requester until their last beat; the result leaves through one output register.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | round-robin search from r_rr_ptr, wrapping N-1 -> 0
//   ST_LOCKED | only r_lock_id may be served; its missing beats are bubbles
module cpa_rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input logic            clk,
  input logic            rst_n,
  cpa_rr_arbiter_if.slave bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  localparam logic [IDW-1:0] L_LAST_ID = IDW'(N - 1);

  state_t         r_state, w_state_nxt;
  logic [IDW-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [IDW-1:0] r_lock_id, w_lock_id_nxt;

  logic           r_out_valid;
  logic [31:0]    r_out_sum;
  logic           r_out_lmode;
  logic [IDW-1:0] r_out_id;
  logic           r_out_last;

  logic           w_lo_any, w_hi_any;
  logic [IDW-1:0] w_lo_id, w_hi_id;
  logic           w_cand_ok;
  logic [IDW-1:0] w_cand_id;
  logic [31:0]    w_a, w_b;
  logic           w_lmode, w_last;
  logic [16:0]    w_sum_lo;
  logic           w_carry_mid;
  logic [15:0]    w_sum_hi;
  logic           w_can_take, w_accept;
  logic [N-1:0]   w_ready;

  function automatic logic [IDW-1:0] inc_mod(input logic [IDW-1:0] x);
    if (x == L_LAST_ID) return '0;
    return x + 1'b1;
  endfunction

  // Lowest valid at or above the pointer wins; otherwise wrap to the lowest valid overall.
  always_comb begin
    w_lo_any = 1'b0;
    w_lo_id  = '0;
    w_hi_any = 1'b0;
    w_hi_id  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.req_valid[k]) begin
        w_lo_any = 1'b1;
        w_lo_id  = IDW'(k);
        if (IDW'(k) >= r_rr_ptr) begin
          w_hi_any = 1'b1;
          w_hi_id  = IDW'(k);
        end
      end
    end
  end

  always_comb begin
    if (r_state == ST_LOCKED) begin
      w_cand_id = r_lock_id;
      w_cand_ok = bus.req_valid[r_lock_id];
    end else begin
      w_cand_id = w_hi_any ? w_hi_id : w_lo_id;
      w_cand_ok = w_lo_any;
    end
  end

  always_comb begin
    w_a     = '0;
    w_b     = '0;
    w_lmode = 1'b0;
    w_last  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (w_cand_id == IDW'(k)) begin
        w_a     = bus.req_a[32*k +: 32];
        w_b     = bus.req_b[32*k +: 32];
        w_lmode = bus.req_lmode[k];
        w_last  = bus.req_last[k];
      end
    end
  end

  // Lane split: lmode=1 kills the carry from bit 15 into bit 16.
  assign w_sum_lo    = {1'b0, w_a[15:0]} + {1'b0, w_b[15:0]};
  assign w_carry_mid = w_sum_lo[16] & ~w_lmode;
  assign w_sum_hi    = w_a[31:16] + w_b[31:16] + {15'b0, w_carry_mid};

  // Gating with rst_n keeps req_ready low while the block is held in reset.
  assign w_can_take = rst_n & (~r_out_valid | bus.out_ready);
  assign w_accept   = w_cand_ok & w_can_take;

  always_comb begin
    w_ready = '0;
    if (w_accept) w_ready[w_cand_id] = 1'b1;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_lock_id_nxt = r_lock_id;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_last) begin
            w_rr_ptr_nxt = inc_mod(w_cand_id);
          end else begin
            w_state_nxt   = ST_LOCKED;
            w_lock_id_nxt = w_cand_id;
          end
        end
      end
      ST_LOCKED: begin
        if (w_accept && w_last) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = inc_mod(r_lock_id);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= '0;
      r_lock_id <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_lock_id <= w_lock_id_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_lmode <= 1'b0;
      r_out_id    <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= {w_sum_hi, w_sum_lo[15:0]};
      r_out_lmode <= w_lmode;
      r_out_id    <= w_cand_id;
      r_out_last  <= w_last;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_lmode = r_out_lmode;
  assign bus.out_id    = r_out_id;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = (r_state == ST_LOCKED);

endmodule

// File: doc/cpa_rr_arbiter.md
# cpa_rr_arbiter

Round-robin arbiter and sequencer that shares one 32/16-bit vector carry-propagate adder among N requesters in the systolic-array accumulation path. Each requester presents two 32-bit addends and a lane mode. The block grants one request per cycle, performs the lane-split addition, and returns the sum with the requester ID through a single registered valid/ready output stage. Multi-beat bursts can lock the adder to one requester until the burst's last beat.

## Interface
- N, 4, number of requesters (2..8)
- IDW, 2, requester ID width, equals clog2(N)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N  request valid, one bit per requester
- req_ready  out  N  request accepted this cycle, at most one bit high
- req_last  in  N  beat is the final beat of a burst
- req_lmode  in  N  lane mode per requester: 0 = one 32-bit add, 1 = two independent 16-bit adds
- req_a  in  32*N  addend A, requester i at bits [32i+31:32i]
- req_b  in  32*N  addend B, same packing as req_a
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_sum  out  32  registered sum
- out_lmode  out  1  lane mode of the result
- out_id  out  IDW  ID of the requester that produced the result
- out_last  out  1  req_last of the beat that produced the result
- busy  out  1  high while in the LOCKED state

## Operation
- Arithmetic when lmode=0: out_sum = (a+b) mod 2^32, with full carry from bit 15 into bit 16.
- Arithmetic when lmode=1: out_sum[15:0] = (a[15:0]+b[15:0]) mod 2^16 and out_sum[31:16] = (a[31:16]+b[31:16]) mod 2^16. No carry crosses bit 15/16.
- Carry out of bit 31, and of bit 15 in lmode=1, is discarded. There is no saturation.
- The output stage can take a new beat (can_take) when out_valid=0 or out_ready=1.
- FSM has two states:
  - IDLE: the candidate is the first requester with req_valid=1, searching from rr_ptr upward and wrapping N-1 to 0.
  - LOCKED: the candidate is lock_id only. All other valid requests wait.
- A beat is accepted when the candidate exists and can_take=1. On acceptance:
  - req_ready[candidate]=1.
  - The sum, lmode, ID and last are loaded into the output register.
- Transitions:
  - IDLE to LOCKED: accept with req_last=0. Set lock_id = candidate.
  - LOCKED to IDLE: accept with req_last=1 from lock_id. Set rr_ptr = (lock_id+1) mod N.
  - IDLE stays IDLE on accept with req_last=1. Set rr_ptr = (candidate+1) mod N.
  - LOCKED with req_valid[lock_id]=0: bubble cycle. The lock is held and other requesters are not served.
- req_ready depends combinationally on req_valid, the state, rr_ptr, out_valid and out_ready. It never depends on req_a, req_b or req_lmode.
- Requesters must hold a, b, lmode and last stable while valid=1 and ready=0. They must not drop valid before the handshake.

## Timing
- Latency: result appears on out_* 1 cycle after the accepting edge.
- Throughput: 1 beat per cycle with out_ready held high.
- When out_valid=1 and out_ready=0:
  - out_* hold stable.
  - All req_ready=0.
  - The FSM and rr_ptr do not change.
- Same cycle, output consumed and new beat accepted: out_valid stays 1 and out_* update to the new beat. There is no bubble.
- Output consumed with no accept: out_valid goes to 0 on the next edge.
- Reset values: out_valid=0, out_sum=0, out_lmode=0, out_id=0, out_last=0, busy=0, req_ready=0, state IDLE, rr_ptr=0, lock_id=0.
- Reset asserted mid-burst:
  - Immediate return to IDLE with rr_ptr=0.
  - Any pending output beat is dropped.
  - After release, arbitration starts from requester 0.
- busy is registered state. It is high from the cycle after a non-last accept until the edge that accepts the last beat.

## Test plan
- Full 32-bit carry: req0 sends a=0x0000FFFF, b=0x00000001, lmode=0, last=1. Require out_sum=0x00010000, out_id=0, out_valid high 1 cycle after the accept.
- Lane split: req1 sends a=0x0001FFFF, b=0x00010001, lmode=1. Require out_sum=0x00020000 with no cross-lane carry. The same operands with lmode=0 require 0x00030000.
- Round-robin fairness (N=4): all four requesters send continuous single-beat requests (last=1) with out_ready=1. Require out_id sequence 0,1,2,3,0,1,… with one result per cycle.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1. Require out_* stable and req_ready=0. Then raise out_ready with req2 valid: require the old beat consumed and the new beat loaded on the same edge.
- Locked burst: req3 sends 3 beats (last=0,0,1) while req0 is also valid, and req3 drops valid for 1 cycle mid-burst. Require busy=1, a bubble with req0 not served, all 3 beats with out_id=3, then out_id=0.
- Reset mid-burst: assert rst_n=0 during a locked req2 burst. Require every output at its reset value, busy=0, and the first grant after release going to the lowest valid requester counted from 0.
